vga_timing_grid: RTL and testbench

Parametrised display timing and pixel-position generator for the TicTacToe video path. It produces its own horizontal/vertical counters, sync pulses and an active-video flag. It tracks the current on-screen pixel position and holds it through blanking. Optionally, it maps the position onto an N×N board grid so that downstream drawing logic receives cell coordinates directly.

---
 rtl/vga_timing_grid.sv | 154 +++++++++++++++
 tb/tb_vga_timing_grid.sv | 130 +++++++++++++
 2 files changed

// File: rtl/vga_timing_grid.sv
// Display timing generator: h/v counters, syncs, active flag, held pixel position and
// optional board-cell mapping (compile with GRID_MAP_EN to build the grid comparators).
module vga_timing_grid #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int GRID_N   = 3,
  parameter int GRID_X0  = 80,
  parameter int GRID_Y0  = 0,
  parameter int CELL_W   = 160,
  parameter int CELL_H   = 160,
  localparam int CW      = (GRID_N > 1) ? $clog2(GRID_N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [9:0]    hcount,
  output logic [9:0]    vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [9:0]    posx,
  output logic [9:0]    posy,
  output logic          frame_start,
  output logic [CW-1:0] cell_col,
  output logic [CW-1:0] cell_row,
  output logic          cell_valid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_grid: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (GRID_X0 + GRID_N * CELL_W > 1024 || GRID_Y0 + GRID_N * CELL_H > 1024) begin : g_bad_grid
    $error("vga_timing_grid: board does not fit in the 10-bit coordinate space");
  end

  logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d;
  logic [9:0]    posx_q, posx_d, posy_q, posy_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          active_q, active_d, frame_start_q, frame_start_d;
  logic [CW-1:0] cell_col_q, cell_col_d, cell_row_q, cell_row_d;
  logic          cell_valid_q, cell_valid_d;
  logic          h_wrap;

  // Every registered output is a function of the *next* counter value, so all of
  // them change on the same edge as hcount/vcount.
  always_comb begin
    h_wrap        = (hcount_q == 10'(H_TOTAL - 1));
    hcount_d      = h_wrap ? '0 : hcount_q + 10'd1;
    vcount_d      = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == 10'(V_TOTAL - 1)) ? '0 : vcount_q + 10'd1;
    end
    hsync_d       = (32'(hcount_d) >= HS_START && 32'(hcount_d) < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (32'(vcount_d) >= VS_START && 32'(vcount_d) < VS_END) ? SYNC_POL : ~SYNC_POL;
    active_d      = (32'(hcount_d) < H_ACTIVE) && (32'(vcount_d) < V_ACTIVE);
    posx_d        = (32'(hcount_d) < H_ACTIVE) ? hcount_d : posx_q;
    posy_d        = (32'(vcount_d) < V_ACTIVE) ? vcount_d : posy_q;
    frame_start_d = pix_en && (hcount_d == '0) && (vcount_d == '0);
  end

`ifdef GRID_MAP_EN
  logic [31:0] px, py;
  logic        col_hit, row_hit;

  // NOTE: every variable assigned in this block gets a default first, otherwise
  // the partially-assigned hit flags and indices would be inferred as latches.
  always_comb begin
    px           = 32'(posx_d);
    py           = 32'(posy_d);
    col_hit      = 1'b0;
    row_hit      = 1'b0;
    cell_col_d   = '0;
    cell_row_d   = '0;
    for (int k = 0; k < GRID_N; k++) begin
      if (px >= 32'(GRID_X0 + k * CELL_W) && px < 32'(GRID_X0 + (k + 1) * CELL_W)) begin
        col_hit    = 1'b1;
        cell_col_d = CW'(k);
      end
      if (py >= 32'(GRID_Y0 + k * CELL_H) && py < 32'(GRID_Y0 + (k + 1) * CELL_H)) begin
        row_hit    = 1'b1;
        cell_row_d = CW'(k);
      end
    end
    cell_valid_d = col_hit && row_hit;
    if (!cell_valid_d) begin
      cell_col_d = '0;
      cell_row_d = '0;
    end
  end
`else
  assign cell_col_d   = '0;
  assign cell_row_d   = '0;
  assign cell_valid_d = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; frame_start is the only one that updates on disabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= 10'(H_TOTAL - 1);
      vcount_q      <= 10'(V_TOTAL - 1);
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      posx_q        <= '0;
      posy_q        <= '0;
      frame_start_q <= 1'b0;
      cell_col_q    <= '0;
      cell_row_q    <= '0;
      cell_valid_q  <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (pix_en) begin
        hcount_q     <= hcount_d;
        vcount_q     <= vcount_d;
        hsync_q      <= hsync_d;
        vsync_q      <= vsync_d;
        active_q     <= active_d;
        posx_q       <= posx_d;
        posy_q       <= posy_d;
        cell_col_q   <= cell_col_d;
        cell_row_q   <= cell_row_d;
        cell_valid_q <= cell_valid_d;
      end
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign posx        = posx_q;
  assign posy        = posy_q;
  assign frame_start = frame_start_q;
  assign cell_col    = cell_col_q;
  assign cell_row    = cell_row_q;
  assign cell_valid  = cell_valid_q;

endmodule

// File: tb/tb_vga_timing_grid.sv
// Randomized pix_en bench for vga_timing_grid on a scaled-down raster so whole frames
// fit in the run; expected values come from a closed-form model of enabled-tick count.
module tb_vga_timing_grid;

  localparam int HA = 20, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;  // 32
  localparam int VT = VA + VFP + VS + VBP;  // 19
  localparam int FT = HT * VT;              // 608 enabled ticks per frame
  localparam bit POL = 1'b0;
  localparam int N = 3, X0 = 3, Y0 = 1, CWD = 5, CHT = 3;

  typedef struct {
    int h, v, hs, vs, act, px, py, col, row, valid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [9:0] hcount, vcount, posx, posy;
  logic       hsync, vsync, active, frame_start, cell_valid;
  logic [1:0] cell_col, cell_row;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;  // enabled edges since last reset

  vga_timing_grid #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .GRID_N(N), .GRID_X0(X0), .GRID_Y0(Y0),
    .CELL_W(CWD), .CELL_H(CHT)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .active(active), .posx(posx), .posy(posy), .frame_start(frame_start),
    .cell_col(cell_col), .cell_row(cell_row), .cell_valid(cell_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
  endtask

  // Position after ticks enabled edges: raster scan from (0,0), pos = last visible coordinate.
  function automatic exp_t model(input int ticks);
    exp_t e;
    int   idx;
    if (ticks == 0) begin
      e = '{h: HT - 1, v: VT - 1, hs: int'(!POL), vs: int'(!POL), act: 0,
            px: 0, py: 0, col: 0, row: 0, valid: 0};
      return e;
    end
    idx     = (ticks - 1) % FT;
    e.h     = idx % HT;
    e.v     = idx / HT;
    e.hs    = (e.h >= HA + HFP && e.h < HA + HFP + HS) ? int'(POL) : int'(!POL);
    e.vs    = (e.v >= VA + VFP && e.v < VA + VFP + VS) ? int'(POL) : int'(!POL);
    e.act   = (e.h < HA && e.v < VA) ? 1 : 0;
    e.px    = (e.h < HA) ? e.h : HA - 1;
    e.py    = (e.v < VA) ? e.v : VA - 1;
    e.col   = 0;
    e.row   = 0;
    e.valid = 0;
`ifdef GRID_MAP_EN
    if (e.px >= X0 && e.px < X0 + N * CWD && e.py >= Y0 && e.py < Y0 + N * CHT) begin
      e.col   = (e.px - X0) / CWD;
      e.row   = (e.py - Y0) / CHT;
      e.valid = 1;
    end
`endif
    return e;
  endfunction

  task automatic check_all(input int fs_exp);
    exp_t e;
    e = model(t);
    check("hcount",      32'(hcount),      32'(e.h));
    check("vcount",      32'(vcount),      32'(e.v));
    check("hsync",       32'(hsync),       32'(e.hs));
    check("vsync",       32'(vsync),       32'(e.vs));
    check("active",      32'(active),      32'(e.act));
    check("posx",        32'(posx),        32'(e.px));
    check("posy",        32'(posy),        32'(e.py));
    check("frame_start", 32'(frame_start), 32'(fs_exp));
    check("cell_col",    32'(cell_col),    32'(e.col));
    check("cell_row",    32'(cell_row),    32'(e.row));
    check("cell_valid",  32'(cell_valid),  32'(e.valid));
  endtask

  initial begin
    bit en;
    int fs;
    rst    = 1'b1;
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    t = 0;
    check_all(0);
    rst = 1'b0;

    for (int cyc = 0; cyc < 3500; cyc++) begin
      // First stretch fully enabled so two frame_start pulses are exactly one frame apart.
      en     = (cyc < 700) ? 1'b1 : ($urandom_range(0, 3) != 0);
      pix_en = en;
      @(posedge clk);
      if (en) t++;
      fs = (en && t > 0 && ((t - 1) % FT) == 0) ? 1 : 0;
      @(negedge clk);
      check_all(fs);

      if (cyc == 1500 || cyc == 2650) begin
        // Async reset between edges must take effect without a clock.
        #2 rst = 1'b1;
        #1;
        t = 0;
        check_all(0);
        @(negedge clk);
        check_all(0);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
